// File: rtl/ramp_capture_gate_pkg.sv
// ramp_capture_pkg: shared definitions for ramp_capture_gate.
//   - one-hot state bit positions and the state enum built from them
//   - NUM_STATES, the width of the one-hot state vector and of dbg_state
//   - default parameter values for the gate and its stream interface
package ramp_capture_pkg;

  localparam int ST_IDLE    = 0;
  localparam int ST_ARMED   = 1;
  localparam int ST_SETTLE  = 2;
  localparam int ST_CAPTURE = 3;
  localparam int NUM_STATES = 4;

  typedef enum logic [NUM_STATES-1:0] {
    S_IDLE    = NUM_STATES'(1 << ST_IDLE),
    S_ARMED   = NUM_STATES'(1 << ST_ARMED),
    S_SETTLE  = NUM_STATES'(1 << ST_SETTLE),
    S_CAPTURE = NUM_STATES'(1 << ST_CAPTURE)
  } state_e;

  localparam int DEF_DATA_W        = 12;
  localparam int DEF_SETTLE_CYCLES = 40;
  localparam int DEF_NUM_SAMPLES   = 20000;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_FRAME_W       = 16;

endpackage

// File: rtl/ramp_capture_gate_if.sv
// ramp_capture_gate_if: ADC input strobe and framed output stream.
//   adc_valid/adc_data : ADC sample strobe and sample (environment -> gate)
//   out_ready          : downstream ready (environment -> gate)
//   out_valid/out_data : framed output word (gate -> environment)
//   out_first/out_last : frame delimiters, qualified by out_valid
// Handshake: a word is transferred in every cycle out_valid=1. The ADC cannot
// stall, so out_valid never waits for out_ready; each word is presented for
// exactly one cycle. out_ready is only observed, and out_valid=1 with
// out_ready=0 is an overrun.
// master = the gate, slave = the environment that drives ADC data and sinks
// the stream.
interface ramp_capture_gate_if #(
  parameter int DATA_W = 12
) ();
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_first;
  logic              out_last;

  modport master (
    input  adc_valid, adc_data, out_ready,
    output out_valid, out_data, out_first, out_last
  );

  modport slave (
    output adc_valid, adc_data, out_ready,
    input  out_valid, out_data, out_first, out_last
  );
endinterface

// File: rtl/ramp_capture_gate_load_down_counter.sv
// load_down_counter: loadable down counter with a zero flag.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   load       : load load_val this cycle (wins over dec)
//   load_val   : value to load
//   dec        : decrement this cycle
//   zero       : count is currently 0
// The caller must not request dec while zero=1; the counter would wrap.
module load_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ramp_capture_gate.sv
// ramp_capture_gate: after each ramp_start pulse waits SETTLE_CYCLES, then
// forwards exactly NUM_SAMPLES ADC samples as one frame tagged first/last.
// Ports:
//   clk, rst_n     : 40 MHz clock, asynchronous active-low reset
//   enable         : level; 1 arms capture, 0 aborts to IDLE
//   ramp_start     : one-cycle sweep-start pulse
//   bus (master)   : ADC strobe/data in, framed stream out, out_ready observed
//   frame_idx      : index of the current/last frame (reset all-ones)
//   busy           : in SETTLE or CAPTURE
//   err_early      : sticky, ramp_start while a frame is in progress
//   err_overrun    : sticky, out_valid while out_ready=0
//   dbg_state      : one-hot state, for observation
// Optional build macro RAMP_CAPTURE_HEADER_EN: emits a header word carrying
// frame_idx (out_first=1) on the cycle after the window opens; frames then
// hold NUM_SAMPLES+1 words and the first sample has out_first=0.
module ramp_capture_gate
  import ramp_capture_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int NUM_SAMPLES   = DEF_NUM_SAMPLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int FRAME_W       = DEF_FRAME_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  ramp_start,
  ramp_capture_gate_if.master   bus,
  output logic [FRAME_W-1:0]    frame_idx,
  output logic                  busy,
  output logic                  err_early,
  output logic                  err_overrun,
  output logic [NUM_STATES-1:0] dbg_state
);

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_first_q, out_first_d;
  logic                out_last_q, out_last_d;
  logic [FRAME_W-1:0]  frame_idx_q, frame_idx_d;
  logic                busy_q, busy_d;
  logic                err_early_q, err_early_d;
  logic                err_overrun_q, err_overrun_d;
  logic                enable_q, enable_d;
  // Set when the window opens; the next accepted sample takes out_first.
  logic                first_pend_q, first_pend_d;

  logic settle_load, settle_dec, settle_zero;
  logic sample_load, sample_dec, sample_zero;

`ifdef RAMP_CAPTURE_HEADER_EN
  // Zero-extend before slicing so any FRAME_W/DATA_W ratio works.
  logic [FRAME_W+DATA_W-1:0] hdr_ext;
  assign hdr_ext = {{DATA_W{1'b0}}, frame_idx_q};
`endif

  load_down_counter #(.W(CNT_W)) u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (settle_load),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .dec      (settle_dec),
    .zero     (settle_zero)
  );

  load_down_counter #(.W(CNT_W)) u_sample_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sample_load),
    .load_val (CNT_W'(NUM_SAMPLES - 1)),
    .dec      (sample_dec),
    .zero     (sample_zero)
  );

  always_comb begin
    state_d       = state_q;
    out_valid_d   = 1'b0;
    out_data_d    = out_data_q;
    out_first_d   = 1'b0;
    out_last_d    = 1'b0;
    frame_idx_d   = frame_idx_q;
    err_early_d   = err_early_q;
    err_overrun_d = err_overrun_q;
    enable_d      = enable;
    first_pend_d  = first_pend_q;
    settle_load   = 1'b0;
    settle_dec    = 1'b0;
    sample_load   = 1'b0;
    sample_dec    = 1'b0;

    // Re-arming clears the sticky flags; a new overrun in the same cycle wins.
    if (enable && !enable_q) begin
      err_early_d   = 1'b0;
      err_overrun_d = 1'b0;
    end
    if (out_valid_q && !bus.out_ready) begin
      err_overrun_d = 1'b1;
    end

    if (!enable) begin
      // Abort: nothing is accepted this cycle, so no out_last for a cut frame.
      state_d      = S_IDLE;
      first_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ARMED;
        end
        S_ARMED: begin
          if (ramp_start) begin
            state_d     = S_SETTLE;
            settle_load = 1'b1;
            frame_idx_d = frame_idx_q + FRAME_W'(1);
          end
        end
        S_SETTLE: begin
          if (ramp_start) begin
            err_early_d = 1'b1;
          end
          if (settle_zero) begin
            state_d     = S_CAPTURE;
            sample_load = 1'b1;
`ifdef RAMP_CAPTURE_HEADER_EN
            out_valid_d  = 1'b1;
            out_first_d  = 1'b1;
            out_data_d   = hdr_ext[DATA_W-1:0];
            first_pend_d = 1'b0;
`else
            first_pend_d = 1'b1;
`endif
          end else begin
            settle_dec = 1'b1;
          end
        end
        S_CAPTURE: begin
          // Includes the out_last cycle: a pulse here is early, not a new frame.
          if (ramp_start) begin
            err_early_d = 1'b1;
          end
          if (bus.adc_valid) begin
            out_valid_d  = 1'b1;
            out_data_d   = bus.adc_data;
            out_first_d  = first_pend_q;
            first_pend_d = 1'b0;
            if (sample_zero) begin
              out_last_d = 1'b1;
              state_d    = S_ARMED;
            end else begin
              sample_dec = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_SETTLE) || (state_d == S_CAPTURE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_first_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_idx_q   <= '1;
      busy_q        <= 1'b0;
      err_early_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      enable_q      <= 1'b0;
      first_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_first_q   <= out_first_d;
      out_last_q    <= out_last_d;
      frame_idx_q   <= frame_idx_d;
      busy_q        <= busy_d;
      err_early_q   <= err_early_d;
      err_overrun_q <= err_overrun_d;
      enable_q      <= enable_d;
      first_pend_q  <= first_pend_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign frame_idx     = frame_idx_q;
  assign busy          = busy_q;
  assign err_early     = err_early_q;
  assign err_overrun   = err_overrun_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ramp_capture_gate.sv
`timescale 1ns/1ps
// Testbench for ramp_capture_gate with SETTLE_CYCLES=4, NUM_SAMPLES=8.
// A frame-level model predicts every output each cycle from the ramp_start
// cycle, the settle delay and a count of accepted samples; a negedge process
// compares the DUT against it, and directed tests pin latency, word counts,
// frame indices and error flags with literal values.
module tb_ramp_capture_gate;
  import ramp_capture_pkg::*;

  localparam int DW     = 12;
  localparam int FW     = 16;
  localparam int SETTLE = 4;
  localparam int NUM    = 8;
`ifdef RAMP_CAPTURE_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif
  localparam int FRAME_WORDS = NUM + (HDR ? 1 : 0);
  localparam int FIRST_LAT   = HDR ? 5 : 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  enable = 1'b0;
  logic                  ramp_start = 1'b0;
  logic [FW-1:0]         frame_idx;
  logic                  busy, err_early, err_overrun;
  logic [NUM_STATES-1:0] dbg_state;

  ramp_capture_gate_if #(.DATA_W(DW)) bif ();

  ramp_capture_gate #(
    .DATA_W(DW), .SETTLE_CYCLES(SETTLE), .NUM_SAMPLES(NUM), .CNT_W(16), .FRAME_W(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ramp_start(ramp_start),
    .bus(bif.master), .frame_idx(frame_idx), .busy(busy),
    .err_early(err_early), .err_overrun(err_overrun), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  int            m_cyc = 0;
  bit            m_en_prev = 0, m_armed = 0, m_active = 0;
  int            m_start = 0, m_taken = 0, rel = 0;
  logic [FW-1:0] m_frame = '1;
  bit            m_err_e = 0, m_err_o = 0;
  bit            e_valid = 0, e_first = 0, e_last = 0, e_busy = 0, pv = 0;
  logic [DW-1:0] e_data = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_en_prev = 0; m_armed = 0; m_active = 0; m_frame = '1;
      m_err_e = 0; m_err_o = 0; e_valid = 0; e_first = 0; e_last = 0; e_busy = 0;
    end else begin
      pv = e_valid;
      e_valid = 0; e_first = 0; e_last = 0;
      if (enable && !m_en_prev) begin m_err_e = 0; m_err_o = 0; end
      if (pv && !bif.out_ready) m_err_o = 1;
      if (!enable) begin
        m_armed = 0; m_active = 0;
      end else if (m_active) begin
        rel = m_cyc - m_start;
        if (ramp_start) m_err_e = 1;
        if (HDR && rel == SETTLE) begin
          e_valid = 1; e_first = 1; e_data = m_frame[DW-1:0];
        end else if (rel > SETTLE && bif.adc_valid) begin
          e_valid = 1; e_data = bif.adc_data;
          e_first = !HDR && (m_taken == 0);
          m_taken++;
          if (m_taken == NUM) begin e_last = 1; m_active = 0; end
        end
      end else if (m_armed) begin
        if (ramp_start) begin
          m_active = 1; m_start = m_cyc; m_taken = 0; m_frame = m_frame + 1'b1;
        end
      end else begin
        m_armed = 1;
      end
      e_busy = m_active;
      m_en_prev = enable;
      m_cyc++;
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [DW-1:0] exp_q[$];  // data words of the current frame, in order
  int  words = 0, lasts = 0;
  time first_t = 0;
  logic [DW-1:0] got_w;

  always @(negedge clk) begin
    chk("out_valid", bif.out_valid, e_valid);
    if (e_valid) begin
      chk("out_data", bif.out_data, e_data);
      chk("out_first", bif.out_first, e_first);
      chk("out_last", bif.out_last, e_last);
    end
    chk("busy", busy, e_busy);
    chk("frame_idx", frame_idx, m_frame);
    chk("err_early", err_early, m_err_e);
    chk("err_overrun", err_overrun, m_err_o);
    if (bif.out_valid) begin
      words++;
      if (bif.out_last) lasts++;
      if (bif.out_first && first_t == 0) first_t = $time;
      if (!(HDR && bif.out_first)) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          got_w = exp_q.pop_front();
          chk("sb_word", bif.out_data, got_w);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic rs, input logic av,
                       input logic [DW-1:0] ad, input logic rdy);
    enable = en; ramp_start = rs;
    bif.adc_valid = av; bif.adc_data = ad; bif.out_ready = rdy;
    @(negedge clk);
  endtask

  // Two armed lead-in cycles, then ramp_start at i=0 and len cycles of ADC
  // data. The ADC sample accepted in window order is pushed to exp_q.
  task automatic frame(input int len, input int rs2_at, input int en_off_at,
                       input int rdy_lo_at, input bit toggle, input logic [DW-1:0] base,
                       output time t_ramp);
    int taken;
    bit av;
    words = 0; lasts = 0; first_t = 0; exp_q.delete();
    taken = 0;
    drive(1, 0, 0, '0, 1);
    drive(1, 0, 0, '0, 1);
    t_ramp = $time;
    for (int i = 0; i < len; i++) begin
      av = toggle ? (i % 2 == 0) : 1'b1;
      if (av && i > SETTLE && i < en_off_at && taken < NUM) begin
        exp_q.push_back(base + DW'(i));
        taken++;
      end
      drive(i < en_off_at, (i == 0) || (i == rs2_at), av, base + DW'(i), i != rdy_lo_at);
    end
    for (int i = 0; i < 3; i++) drive(en_off_at > len, 0, 0, '0, 1);
  endtask

  time t0;

  initial begin
    bif.adc_valid = 0; bif.adc_data = '0; bif.out_ready = 1;
    // Reset values, checked while reset is still held.
    @(negedge clk);
    @(negedge clk);
    chk("rst_frame_idx", frame_idx, 32'hFFFF);
    chk("rst_out_valid", bif.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {err_early, err_overrun}, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, '0, 1);

    // T1: constant adc_valid, clean frame 0.
    frame(20, -1, 1000, -1, 0, 12'h100, t0);
    chk("t1_latency", (first_t - t0) / 10, FIRST_LAT);
    chk("t1_words", words, FRAME_WORDS);
    chk("t1_lasts", lasts, 1);
    chk("t1_frame", frame_idx, 0);
    chk("t1_busy", busy, 0);

    // T2: adc_valid toggling; still 8 samples in order.
    frame(26, -1, 1000, -1, 1, 12'h200, t0);
    chk("t2_words", words, FRAME_WORDS);
    chk("t2_lasts", lasts, 1);
    chk("t2_sb_empty", exp_q.size(), 0);
    chk("t2_frame", frame_idx, 1);

    // T3: second pulse mid-capture is flagged and ignored.
    frame(20, 7, 1000, -1, 0, 12'h300, t0);
    chk("t3_err_early", err_early, 1);
    chk("t3_words", words, FRAME_WORDS);
    chk("t3_frame", frame_idx, 2);
    drive(0, 0, 0, '0, 1);
    drive(1, 0, 0, '0, 1);
    chk("t3_err_cleared", err_early, 0);

    // T4: pulse on the out_last sample cycle is flagged, starts no frame.
    frame(20, NUM + SETTLE, 1000, -1, 0, 12'h400, t0);
    chk("t4_err_early", err_early, 1);
    chk("t4_frame", frame_idx, 3);
    chk("t4_busy", busy, 0);
    frame(20, -1, 1000, -1, 0, 12'h480, t0);
    chk("t4_next_frame", frame_idx, 4);

    // T5: enable drops at the third sample; no out_last, idle.
    frame(20, -1, 7, -1, 0, 12'h500, t0);
    chk("t5_lasts", lasts, 0);
    chk("t5_busy", busy, 0);
    chk("t5_words_short", words < FRAME_WORDS, 1);
    frame(20, -1, 1000, -1, 0, 12'h580, t0);
    chk("t5_full_words", words, FRAME_WORDS);
    chk("t5_frame", frame_idx, 6);

    // T6: one cycle of out_ready=0 while a word is presented.
    frame(20, -1, 1000, 8, 0, 12'h600, t0);
    chk("t6_overrun", err_overrun, 1);
    chk("t6_words", words, FRAME_WORDS);
    drive(1, 0, 0, '0, 1);
    chk("t6_sticky", err_overrun, 1);

    // T7: ramp_start while disabled is ignored without a flag.
    drive(0, 0, 0, '0, 1);
    drive(1, 0, 0, '0, 1);
    drive(0, 1, 1, 12'h7FF, 1);
    drive(0, 0, 0, '0, 1);
    chk("t7_frame", frame_idx, 7);
    chk("t7_err_early", err_early, 0);
    chk("t7_out_valid", bif.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
